// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding plus hazard stall generation, with a one-entry
// register scoreboard for a single in-flight fixed-latency MDU op.
module fwd_hazard_unit #(
  parameter int AW      = 5,
  parameter int NUM_RD  = 2,
  parameter int MDU_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_RD*AW-1:0] id_rs,
  input  logic [NUM_RD-1:0]    id_rs_used,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_regwrite,
  input  logic                 id_is_mdu,
  input  logic [NUM_RD*AW-1:0] ex_rs,
  input  logic [AW-1:0]        ex_rd,
  input  logic                 ex_regwrite,
  input  logic                 ex_memread,
  input  logic                 ex_mdu_start,
  input  logic [AW-1:0]        mem_rd,
  input  logic                 mem_regwrite,
  input  logic [AW-1:0]        wb_rd,
  input  logic                 wb_regwrite,
  input  logic                 mdu_kill,
  output logic [2*NUM_RD-1:0]  ex_fwd_sel,
  output logic                 stall,
  output logic                 mdu_busy,
  output logic                 mdu_done,
  output logic [AW-1:0]        mdu_done_rd,
  output logic [(2**AW)-1:0]   pending
);

  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_rd, w_rd_nxt;
  logic          r_pend, w_pend_nxt;
  logic          w_start;
  logic          w_raw, w_waw, w_struct;

  // Forwarding: the younger EX/MEM result has priority over MEM/WB.
  always_comb begin
    ex_fwd_sel = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (mem_regwrite && mem_rd != '0 && mem_rd == ex_rs[i*AW +: AW])
        ex_fwd_sel[2*i +: 2] = 2'b10;
      else if (wb_regwrite && wb_rd != '0 && wb_rd == ex_rs[i*AW +: AW])
        ex_fwd_sel[2*i +: 2] = 2'b01;
    end
  end

  // Pending is derived from the single tracked entry, so x0 can never be set.
  always_comb begin
    pending = '0;
    if (r_pend)
      pending[r_rd] = 1'b1;
  end

  assign mdu_busy    = (r_state != S_IDLE);
  assign mdu_done    = (r_state == S_DONE) && !mdu_kill;
  assign mdu_done_rd = r_rd;

  always_comb begin
    w_raw = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (id_rs_used[i] && id_rs[i*AW +: AW] != '0) begin
        if (ex_memread && ex_regwrite && ex_rd == id_rs[i*AW +: AW])
          w_raw = 1'b1;
        if (ex_mdu_start && ex_rd == id_rs[i*AW +: AW])
          w_raw = 1'b1;
        if (pending[id_rs[i*AW +: AW]])
          w_raw = 1'b1;
      end
    end
  end

  assign w_waw    = id_regwrite && id_rd != '0 && pending[id_rd];
  assign w_struct = id_is_mdu && (mdu_busy || ex_mdu_start);
  assign stall    = w_raw || w_waw || w_struct;

  assign w_start = ex_mdu_start && !mdu_kill;

  // DONE is the cycle in which the counter has run down to zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_nxt    = r_rd;
    w_pend_nxt  = r_pend;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CNT_LOAD;
          w_rd_nxt    = ex_rd;
          w_pend_nxt  = (ex_rd != '0);
        end
      end
      S_BUSY: begin
        if (mdu_kill) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_pend_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == CW'(1))
            w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_pend_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rd    <= w_rd_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: per-cycle expected output words are
// queued as stimulus is driven and popped when the cycle's outputs settle.
module tb_fwd_hazard_unit;
  localparam int AW = 5;
  localparam int NUM_RD = 2;
  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [NUM_RD*AW-1:0] id_rs;
  logic [NUM_RD-1:0]    id_rs_used;
  logic [AW-1:0]        id_rd;
  logic                 id_regwrite, id_is_mdu;
  logic [NUM_RD*AW-1:0] ex_rs;
  logic [AW-1:0]        ex_rd;
  logic                 ex_regwrite, ex_memread, ex_mdu_start;
  logic [AW-1:0]        mem_rd, wb_rd;
  logic                 mem_regwrite, wb_regwrite, mdu_kill;
  logic [2*NUM_RD-1:0]  ex_fwd_sel;
  logic                 stall, mdu_busy, mdu_done;
  logic [AW-1:0]        mdu_done_rd;
  logic [(2**AW)-1:0]   pending;

  fwd_hazard_unit #(.AW(AW), .NUM_RD(NUM_RD), .MDU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_mdu(id_is_mdu),
    .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_mdu_start(ex_mdu_start),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .mdu_kill(mdu_kill),
    .ex_fwd_sel(ex_fwd_sel), .stall(stall), .mdu_busy(mdu_busy),
    .mdu_done(mdu_done), .mdu_done_rd(mdu_done_rd), .pending(pending)
  );

  // Word layout: {sel[3:0], stall, busy, done, done_rd[4:0], pending[31:0]}
  wire [43:0] obs = {ex_fwd_sel, stall, mdu_busy, mdu_done,
                     (mdu_done ? mdu_done_rd : 5'd0), pending};

  int n_cmp = 0;
  int n_bad = 0;
  logic [43:0] exp_q[$];
  logic [43:0] got, want;

  function automatic logic [43:0] ex(input logic [3:0] sel, input logic st, input logic bz,
                                     input logic dn, input logic [4:0] rd, input logic [31:0] pd);
    return {sel, st, bz, dn, rd, pd};
  endfunction

  function automatic logic [31:0] oh(input int r);
    return (r == 0) ? 32'd0 : (32'd1 << r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1;
    id_rs = '0; id_rs_used = '0; id_rd = '0; id_regwrite = 1'b0; id_is_mdu = 1'b0;
    ex_rs = '0; ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_mdu_start = 1'b0;
    mem_rd = '0; mem_regwrite = 1'b0; wb_rd = '0; wb_regwrite = 1'b0; mdu_kill = 1'b0;
  endtask

  task automatic test_reset();
    logic bz;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    exp_q.push_back(ex(4'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0));
    #2; got = obs; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL reset_init: got %h want %h", got, want); end
    // Reset held for two cycles while an op to x9 is in flight.
    for (int c = 0; c < 8; c++) begin
      tick();
      idle_inputs();
      if (c == 0) begin ex_mdu_start = 1'b1; ex_rd = 5'd9; end
      if (c == 2 || c == 3) rst_n = 1'b0;
      bz = (c == 1 || c == 2);
      exp_q.push_back(ex(4'b0, 1'b0, bz, 1'b0, 5'd0, bz ? oh(9) : 32'd0));
      #2; got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL reset_midop c%0d: got %h want %h", c, got, want); end
      if (c == 4) begin
        n_cmp++;
        if (mdu_done_rd !== 5'd0) begin
          n_bad++; $display("FAIL reset_done_rd: got %0d want 0", mdu_done_rd);
        end
      end
    end
  endtask

  task automatic test_forward();
    logic [9:0] t_ex_rs [5];
    logic [4:0] t_mem [5];
    logic [4:0] t_wb [5];
    logic       t_mw [5];
    logic [3:0] t_sel [5];
    t_ex_rs = '{{5'd3, 5'd5}, {5'd3, 5'd5}, {5'd0, 5'd0}, {5'd7, 5'd7}, {5'd4, 5'd7}};
    t_mem   = '{5'd5, 5'd5, 5'd0, 5'd7, 5'd4};
    t_wb    = '{5'd5, 5'd5, 5'd0, 5'd7, 5'd7};
    t_mw    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    t_sel   = '{4'b0010, 4'b0001, 4'b0000, 4'b1010, 4'b1001};
    for (int k = 0; k < 5; k++) begin
      tick();
      idle_inputs();
      ex_rs = t_ex_rs[k]; mem_rd = t_mem[k]; wb_rd = t_wb[k];
      mem_regwrite = t_mw[k]; wb_regwrite = 1'b1;
      exp_q.push_back(ex(t_sel[k], 1'b0, 1'b0, 1'b0, 5'd0, 32'd0));
      #2; got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL fwd k%0d: got %h want %h", k, got, want); end
    end
  endtask

  task automatic test_load_use();
    logic [9:0] t_rs [6];
    logic [1:0] t_used [6];
    logic       t_mr [6];
    logic       t_rw [6];
    logic [4:0] t_rd [6];
    logic       t_st [6];
    t_rs   = '{{5'd7, 5'd2}, {5'd7, 5'd2}, {5'd7, 5'd2}, {5'd7, 5'd2}, {5'd0, 5'd0}, {5'd2, 5'd7}};
    t_used = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b11, 2'b01};
    t_mr   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    t_rw   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    t_rd   = '{5'd7, 5'd0, 5'd7, 5'd7, 5'd0, 5'd7};
    t_st   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 6; k++) begin
      tick();
      idle_inputs();
      id_rs = t_rs[k]; id_rs_used = t_used[k];
      ex_memread = t_mr[k]; ex_regwrite = t_rw[k]; ex_rd = t_rd[k];
      exp_q.push_back(ex(4'b0, t_st[k], 1'b0, 1'b0, 5'd0, 32'd0));
      #2; got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL load_use k%0d: got %h want %h", k, got, want); end
    end
  endtask

  task automatic test_mdu_raw();
    logic bz, dn;
    for (int c = 0; c <= LAT + 1; c++) begin
      tick();
      idle_inputs();
      id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
      if (c == 0) begin ex_mdu_start = 1'b1; ex_rd = 5'd9; end
      bz = (c >= 1 && c <= LAT);
      dn = (c == LAT);
      exp_q.push_back(ex(4'b0, c <= LAT, bz, dn, dn ? 5'd9 : 5'd0, bz ? oh(9) : 32'd0));
      #2; got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL mdu_raw c%0d: got %h want %h", c, got, want); end
    end
  endtask

  task automatic test_struct_waw();
    int p, k, rdv;
    logic bz, dn, st;
    for (int c = 0; c < 18; c++) begin
      p = c / 6; k = c % 6;
      rdv = (p == 2) ? 0 : 12;
      tick();
      idle_inputs();
      if (p == 0) id_is_mdu = 1'b1;
      if (p == 1) begin id_regwrite = 1'b1; id_rd = 5'd12; end
      if (p == 2) begin id_regwrite = 1'b1; id_rd = 5'd0; id_rs = '0; id_rs_used = 2'b01; end
      if (k == 0) begin ex_mdu_start = 1'b1; ex_rd = 5'(rdv); end
      bz = (k >= 1 && k <= 4);
      dn = (k == 4);
      st = (p == 0) ? (k <= 4) : (p == 1) ? bz : 1'b0;
      exp_q.push_back(ex(4'b0, st, bz, dn, dn ? 5'(rdv) : 5'd0, bz ? oh(rdv) : 32'd0));
      #2; got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL struct_waw p%0d k%0d: got %h want %h", p, k, got, want); end
    end
  endtask

  task automatic test_back_to_back();
    logic bz, dn;
    int rdv;
    for (int c = 0; c <= 10; c++) begin
      tick();
      idle_inputs();
      id_rs_used = 2'b01;
      if (c <= 4) begin id_is_mdu = 1'b1; id_rs = {5'd0, 5'd3}; end
      else id_rs = {5'd0, 5'd4};
      if (c == 0) begin ex_mdu_start = 1'b1; ex_rd = 5'd3; end
      if (c == 5) begin ex_mdu_start = 1'b1; ex_rd = 5'd4; end
      rdv = (c <= 4) ? 3 : 4;
      bz = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
      dn = (c == 4 || c == 9);
      exp_q.push_back(ex(4'b0, c <= 9, bz, dn, dn ? 5'(rdv) : 5'd0, bz ? oh(rdv) : 32'd0));
      #2; got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL back_to_back c%0d: got %h want %h", c, got, want); end
    end
  endtask

  task automatic test_kill();
    logic bz;
    // Kill two cycles after issue; the dependent ID instruction reads x9.
    for (int c = 0; c < 5; c++) begin
      tick();
      idle_inputs();
      id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
      if (c == 0) begin ex_mdu_start = 1'b1; ex_rd = 5'd9; end
      if (c == 2) mdu_kill = 1'b1;
      bz = (c == 1 || c == 2);
      exp_q.push_back(ex(4'b0, c <= 2, bz, 1'b0, 5'd0, bz ? oh(9) : 32'd0));
      #2; got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL kill_busy c%0d: got %h want %h", c, got, want); end
    end
    // Kill in the completion cycle masks the done strobe.
    for (int c = 0; c < 6; c++) begin
      tick();
      idle_inputs();
      if (c == 0) begin ex_mdu_start = 1'b1; ex_rd = 5'd9; end
      if (c == LAT) mdu_kill = 1'b1;
      bz = (c >= 1 && c <= LAT);
      exp_q.push_back(ex(4'b0, 1'b0, bz, 1'b0, 5'd0, bz ? oh(9) : 32'd0));
      #2; got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL kill_done c%0d: got %h want %h", c, got, want); end
    end
    // Kill together with start: nothing is issued.
    for (int c = 0; c < 3; c++) begin
      tick();
      idle_inputs();
      if (c == 0) begin ex_mdu_start = 1'b1; ex_rd = 5'd9; mdu_kill = 1'b1; end
      exp_q.push_back(ex(4'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0));
      #2; got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL kill_start c%0d: got %h want %h", c, got, want); end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_forward();
    test_load_use();
    test_mdu_raw();
    test_struct_waw();
    test_back_to_back();
    test_kill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the EX-stage forwarding unit of the 5-stage RISC-V pipeline.
- Generates forwarding selects for NUM_RD source operands.
- Adds load-use and structural stall detection.
- Adds a register scoreboard for one in-flight multi-cycle MDU op (mul/div) of fixed latency MDU_LAT, so dependent instructions stall until the MDU result is in the register file.

Parameters:
AW, 5, register address width; register 0 is hard-zero.
NUM_RD, 2, source operands per instruction.
MDU_LAT, 4, cycles from MDU issue to MDU writeback; legal range 2..15.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
id_rs  in  NUM_RD*AW  ID-stage source regs, operand i at [i*AW +: AW]
id_rs_used  in  NUM_RD  operand i actually read by the ID instruction
id_rd  in  AW  ID-stage destination
id_regwrite  in  1  ID instruction writes id_rd
id_is_mdu  in  1  ID instruction is an MDU op
ex_rs  in  NUM_RD*AW  ID/EX source regs
ex_rd  in  AW  ID/EX destination
ex_regwrite  in  1  ID/EX writes ex_rd
ex_memread  in  1  ID/EX instruction is a load
ex_mdu_start  in  1  MDU op in EX is issued this cycle
mem_rd  in  AW  EX/MEM destination
mem_regwrite  in  1  EX/MEM write enable
wb_rd  in  AW  MEM/WB destination
wb_regwrite  in  1  MEM/WB write enable
mdu_kill  in  1  flush (branch/interrupt) kills the in-flight MDU op
ex_fwd_sel  out  2*NUM_RD  per-operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
mdu_busy  out  1  MDU op in flight
mdu_done  out  1  one-cycle MDU writeback strobe
mdu_done_rd  out  AW  destination of the completing MDU op
pending  out  2**AW  scoreboard bit vector

Behaviour:
- Clock and reset: single clock `clk`; `rst_n` is synchronous and active-low. While `rst_n` is low at the edge, clear `pending` and the counter, and clear `mdu_busy`, `mdu_done` and `mdu_done_rd`. Reset mid-op discards the op with no done strobe.
- Forwarding, combinational, per operand i:
  - Select 10 if mem_regwrite && mem_rd==ex_rs[i] && mem_rd!=0.
  - Else select 01 if wb_regwrite && wb_rd==ex_rs[i] && wb_rd!=0.
  - Else select 00.
- MDU ops carry ex/mem/wb_regwrite=0; their writeback uses only mdu_done.
- Scoreboard:
  - On ex_mdu_start && !mdu_kill with ex_rd!=0 at edge T: set pending[ex_rd], latch rd, load counter with MDU_LAT-1, set mdu_busy.
  - ex_rd==0: the op still occupies the MDU, but no pending bit is set.
  - Counter decrements each cycle while busy.
  - mdu_done is high exactly in cycle T+MDU_LAT with mdu_done_rd = latched rd. At the end of that cycle, pending[rd] and mdu_busy clear.
  - pending[0] is always 0.
- States: IDLE -> (start) -> BUSY -> (counter==0) -> DONE (one cycle) -> IDLE.
  - DONE -> BUSY directly is impossible, because the structural stall blocks issue.
- Kill:
  - mdu_kill in any BUSY/DONE cycle returns the unit to IDLE at the edge and clears the latched pending bit.
  - mdu_done is masked low in a cycle where mdu_kill is high.
  - mdu_kill with ex_mdu_start in the same cycle: kill wins, start ignored.
- Stall, combinational, OR of the following, with x0 excluded throughout:
  - Load-use: ex_memread && ex_regwrite && ex_rd!=0 && any used id_rs == ex_rd.
  - MDU-in-EX RAW: ex_mdu_start && ex_rd!=0 && any used id_rs == ex_rd.
  - Scoreboard RAW: any used id_rs with pending set.
  - Scoreboard WAW: id_regwrite && id_rd!=0 && pending[id_rd].
  - Structural: id_is_mdu && (mdu_busy || ex_mdu_start).
- Scoreboard stalls hold through the DONE cycle and release the following cycle, once the regfile is written.
- Unused operands (id_rs_used=0) never cause a stall.

Test Plan:
- Reset: hold rst_n=0 two cycles during a busy MDU op -> pending==0, mdu_busy=0, mdu_done never pulses, stall=0.
- Forward priority: mem_rd=wb_rd=ex_rs[0]=5, both regwrite=1 -> sel[0]=10; mem_regwrite=0 -> 01; rd=0 with both enables -> 00.
- Load-use: ex_memread=1, ex_rd=7, id_rs[1]=7 used -> stall=1 for one cycle. Same input with id_rs_used[1]=0 -> stall=0.
- MDU RAW, MDU_LAT=4:
  - Inputs: start at cycle T with rd=9, ID reads x9.
  - Stall and mdu_busy: stall=1 in cycles T..T+4; mdu_busy=1 in T+1..T+4.
  - Done and release: mdu_done=1 only in T+4 with mdu_done_rd=9; stall=0 and pending[9]=0 at T+5.
- Structural and WAW: a second MDU op in ID during busy stalls until the cycle after done. A non-MDU ID write to the pending rd also stalls.
- Kill: mdu_kill at T+2 -> pending[9]=0 and mdu_busy=0 at T+3, no mdu_done pulse. Kill together with start -> no pending bit set.
